// File: rtl/load_store_unit_if.sv
// Core/memory-facing bundle for the load/store unit: request handshake plus word-memory port.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] load_data;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  // Core + memory side: issues requests, returns read data.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
    input  busy, done, err, load_data, mem_A, mem_WD, mem_WE
  );

  // Load/store unit side.
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
    output busy, done, err, load_data, mem_A, mem_WD, mem_WE
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: sub-word loads with extension, sub-word stores via read-modify-write.
module load_store_unit #(
  parameter bit Check_Align = 1'b1
) (
  input logic               clk,
  input logic               reset,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, MERGE = 2'd1, RESP = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] old_q, old_d;
  logic [15:0] wdata_q, wdata_d;
  logic        half_q, half_d;
  logic        err_q, err_d;
  logic [31:0] load_data_q, load_data_d;

  logic        req_illegal_c, req_misal_c, req_err_c, req_sw_c;
  logic [7:0]  ld_byte_c;
  logic [15:0] ld_half_c;
  logic [31:0] ld_ext_c;
  logic [31:0] merged_c;

  // Decode the incoming request and extract/extend load data from the read word.
  always_comb begin
    req_illegal_c = 1'b0;
    req_misal_c   = 1'b0;
    ld_byte_c     = 8'h00;
    ld_half_c     = 16'h0000;
    ld_ext_c      = 32'h0;
    if (bus.req_we) begin
      req_illegal_c = !(bus.req_funct3 == 3'b000 || bus.req_funct3 == 3'b001 ||
                        bus.req_funct3 == 3'b010);
    end else begin
      req_illegal_c = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
    end
    if (Check_Align) begin
      req_misal_c = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                    ((bus.req_funct3 == 3'b010) && (bus.req_addr[1:0] != 2'b00));
    end
    req_err_c = req_illegal_c || req_misal_c;
    req_sw_c  = bus.req_we && (bus.req_funct3 == 3'b010) && !req_err_c;
    case (bus.req_addr[1:0])
      2'd0:    ld_byte_c = bus.mem_RD[7:0];
      2'd1:    ld_byte_c = bus.mem_RD[15:8];
      2'd2:    ld_byte_c = bus.mem_RD[23:16];
      default: ld_byte_c = bus.mem_RD[31:24];
    endcase
    ld_half_c = bus.req_addr[1] ? bus.mem_RD[31:16] : bus.mem_RD[15:0];
    case (bus.req_funct3)
      3'b000:  ld_ext_c = {{24{ld_byte_c[7]}}, ld_byte_c};
      3'b001:  ld_ext_c = {{16{ld_half_c[15]}}, ld_half_c};
      3'b010:  ld_ext_c = bus.mem_RD;
      3'b100:  ld_ext_c = {24'h0, ld_byte_c};
      3'b101:  ld_ext_c = {16'h0, ld_half_c};
      default: ld_ext_c = 32'h0;
    endcase
  end

  // Replace the target lane of the latched old word with the store data.
  always_comb begin
    merged_c = old_q;
    if (half_q) begin
      if (addr_q[1]) merged_c[31:16] = wdata_q;
      else           merged_c[15:0]  = wdata_q;
    end else begin
      case (addr_q[1:0])
        2'd0:    merged_c[7:0]   = wdata_q[7:0];
        2'd1:    merged_c[15:8]  = wdata_q[7:0];
        2'd2:    merged_c[23:16] = wdata_q[7:0];
        default: merged_c[31:24] = wdata_q[7:0];
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: only legal SB/SH pass through MERGE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_we && !req_err_c && !req_sw_c) state_d = MERGE;
          else                                       state_d = RESP;
        end
      end
      MERGE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory port and latch updates; reset kills any write in flight.
  always_comb begin
    bus.mem_WE  = 1'b0;
    bus.mem_WD  = 32'h0;
    bus.mem_A   = {addr_q[31:2], 2'b00};
    addr_d      = addr_q;
    old_d       = old_q;
    wdata_d     = wdata_q;
    half_d      = half_q;
    err_d       = err_q;
    load_data_d = load_data_q;
    case (state_q)
      IDLE: begin
        bus.mem_A = {bus.req_addr[31:2], 2'b00};
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          old_d   = bus.mem_RD;
          wdata_d = bus.req_wdata[15:0];
          half_d  = bus.req_funct3[0];
          err_d   = req_err_c;
          if (req_err_c)       load_data_d = 32'h0;
          else if (!bus.req_we) load_data_d = ld_ext_c;
          if (req_sw_c) begin
            bus.mem_WE = 1'b1;
            bus.mem_WD = bus.req_wdata;
          end
        end
      end
      MERGE: begin
        bus.mem_WE = 1'b1;
        bus.mem_WD = merged_c;
      end
      default: ;
    endcase
    if (reset) begin
      bus.mem_WE = 1'b0;
      bus.mem_WD = 32'h0;
      bus.mem_A  = 32'h0;
    end
  end

  // Datapath latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= 32'h0;
      old_q       <= 32'h0;
      wdata_q     <= 16'h0;
      half_q      <= 1'b0;
      err_q       <= 1'b0;
      load_data_q <= 32'h0;
    end else begin
      addr_q      <= addr_d;
      old_q       <= old_d;
      wdata_q     <= wdata_d;
      half_q      <= half_d;
      err_q       <= err_d;
      load_data_q <= load_data_d;
    end
  end

  // Handshake outputs decoded straight from the state flops.
  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.done      = (state_q == RESP);
    bus.err       = (state_q == RESP) && err_q;
    bus.load_data = load_data_q;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's execute/control logic and the word-addressed data memory. The memory has word read (combinational RD), word write (WE, captured on clk), and word index A[31:2].
- Implements the RV32I sub-word loads LB/LH/LBU/LHU with sign/zero extension, and sub-word stores SB/SH via a two-cycle read-modify-write.
- Detects misaligned and illegal accesses.
- Uses a valid/busy/done handshake so the core stalls while an access is in flight.

Parameters:
- Check_Align, 1: 1 = misaligned access raises err with no memory effect; 0 = address low bits are ignored (force-aligned access, no err).

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on rising clk
- req_valid  input  1  core requests an access; held stable by core until done
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  input  32  byte address
- req_wdata  input  32  store data; byte/half taken from low bits
- busy  output  1  high whenever FSM not in IDLE
- done  output  1  one-cycle completion pulse
- err  output  1  valid with done; misaligned or illegal funct3
- load_data  output  32  registered, extended load result; valid with done, held until next done
- mem_A  output  32  memory address, always {req/latched addr[31:2], 2'b00}
- mem_WD  output  32  memory write data
- mem_WE  output  1  memory write enable
- mem_RD  input  32  memory combinational read data

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, err=0, load_data=0, mem_WE=0, mem_WD=0, mem_A=0, all latches cleared.
- States: IDLE, MERGE, RESP.
- IDLE, req_valid=0: mem_WE=0, no transition.
- IDLE, req_valid=1: latch addr, funct3, wdata, we, and mem_RD (old word). mem_A is driven from req_addr this cycle.
  - Illegal op: store with funct3 not in {000,001,010}, or load with funct3 in {011,110,111}. Result: err_latched=1, no write, go to RESP.
  - Misaligned (Check_Align=1): H/HU with addr[0]=1, or W with addr[1:0]!=0. Result: err_latched=1, no write, go to RESP.
  - Load: compute the extended value from mem_RD and register it into load_data; go to RESP.
  - SW aligned: mem_WE=1 and mem_WD=req_wdata combinationally this cycle; go to RESP.
  - SB/SH: mem_WE=0; go to MERGE.
- MERGE (1 cycle):
  - mem_A from the latched address; mem_WE=1.
  - mem_WD is the latched old word with the target lane replaced.
  - SB lane = addr[1:0], byte = wdata[7:0].
  - SH lane = addr[1], half = wdata[15:0]. With Check_Align=0, addr[0] is ignored.
  - Go to RESP.
- RESP (1 cycle): done=1, err=err_latched, mem_WE=0, requests ignored, go to IDLE.
- Core contract: drop or change req_valid in the cycle after done. A request still valid in IDLE is a new access.
- Load extraction:
  - byte = word[8*addr[1:0] +: 8]; half = word[16*addr[1] +: 16].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- err=1 forces load_data=0 for that access.
- Latency: load, SW, and error take 2 cycles from accept to done. SB/SH take 3 cycles.
- busy rises the cycle after accept. The core must treat req_valid & ~done as a stall.
- Reset mid-operation: the FSM returns to IDLE on that edge and no write is issued. If reset is high during MERGE, mem_WE is forced 0 combinationally, so the partial store is lost, not corrupted.
- mem_WE is never high in RESP, or in IDLE without a legal aligned SW.

Test Plan:
- Mem[1]=0x8899AABB; LB @0x07 -> done after 2 cycles, load_data=0xFFFFFF88, err=0. LBU @0x07 -> 0x00000088.
- Mem[1]=0x8899AABB; LH @0x04 -> 0xFFFFAABB. LHU @0x06 -> 0x00008899. LW @0x04 -> 0x8899AABB.
- Mem[2]=0x11223344; SB @0x09 wdata=0xDEADBEEF -> mem_WE only in MERGE, Mem[2]=0x1122EF44, done on cycle 3. Then SH @0x0A wdata=0x0000CAFE -> Mem[2]=0xCAFEEF44.
- SW @0x0C wdata=0xA5A5A5A5 -> mem_WE in accept cycle, Mem[3]=0xA5A5A5A5, done next cycle.
- Check_Align=1: LW @0x06, then SH @0x05 -> done with err=1, load_data=0, mem_WE never high, memory unchanged. Store with funct3=100 -> err=1.
- Assert reset during MERGE of SB @0x09 -> mem_WE=0, busy=0 the next cycle, Mem[2] unchanged. Subsequent LW @0x08 completes normally.
